// File: rtl/pc_ctrl_if.sv
// Fetch-stage next-PC bus: D-stage/CP0 control in, PC_F/NPC and redirect status out.
interface pc_ctrl_if #(
    parameter int unsigned SEL_W = 3
);
    logic             Stall;
    logic             Req;
    logic [31:0]      EPC;
    logic [31:0]      PC_D;
    logic [25:0]      imm26;
    logic [31:0]      EXT;
    logic [31:0]      RD1;
    logic [31:0]      RD2;
    logic [SEL_W-1:0] nPC_sel;
    logic             brz_sel;
    logic [31:0]      PC_F;
    logic [31:0]      NPC;
    logic             flush;
    logic             ExcAdEL_F;
    logic             taken;

    // Decoder/CP0 side
    modport master (
        output Stall, Req, EPC, PC_D, imm26, EXT, RD1, RD2, nPC_sel, brz_sel,
        input  PC_F, NPC, flush, ExcAdEL_F, taken
    );

    // PC unit side
    modport slave (
        input  Stall, Req, EPC, PC_D, imm26, EXT, RD1, RD2, nPC_sel, brz_sel,
        output PC_F, NPC, flush, ExcAdEL_F, taken
    );
endinterface

// File: rtl/pc_ctrl.sv
// F-stage PC register and next-PC selection (sequential, branch, jump, eret, exception),
// with a retry state for an eret held off by a D-stage stall.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc,
    parameter int unsigned SEL_W      = 3
) (
    input  logic       clk,
    input  logic       reset,
    pc_ctrl_if.slave   bus
);

    localparam logic [SEL_W-1:0] SEL_PC4  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_J    = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_JR   = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_BEQ  = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_BNE  = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_BLEZ = SEL_W'(5);
    localparam logic [SEL_W-1:0] SEL_BGTZ = SEL_W'(6);
    localparam logic [SEL_W-1:0] SEL_ERET = SEL_W'(7);

    typedef enum logic {
        RUN       = 1'b0,
        ERET_WAIT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic signed [31:0] rs_s, rt_s;
    logic [31:0] pc_plus4_c, br_target_c, j_target_c, sel_npc_c;
    logic        br_cond_c, sel_xfer_c, sel_eret_c;
    logic        flush_c, taken_c;

    assign rs_s = $signed(bus.RD1);
    assign rt_s = $signed(bus.RD2);

    // Branch condition; brz_sel turns blez/bgtz into bltz/bgez
    always_comb begin
        br_cond_c = 1'b0;
        case (bus.nPC_sel)
            SEL_BEQ:  br_cond_c = (rs_s == rt_s);
            SEL_BNE:  br_cond_c = (rs_s != rt_s);
            SEL_BLEZ: br_cond_c = bus.brz_sel ? (rs_s < 32'sd0)  : (rs_s <= 32'sd0);
            SEL_BGTZ: br_cond_c = bus.brz_sel ? (rs_s >= 32'sd0) : (rs_s > 32'sd0);
            default:  br_cond_c = 1'b0;
        endcase
    end

    // Target chosen by the D-stage instruction alone
    always_comb begin
        pc_plus4_c  = pc_q + 32'd4;
        br_target_c = bus.PC_D + 32'd4 + (bus.EXT << 2);
        j_target_c  = {bus.PC_D[31:28], bus.imm26, 2'b00};
        sel_npc_c   = pc_plus4_c;
        sel_xfer_c  = 1'b0;
        sel_eret_c  = 1'b0;
        case (bus.nPC_sel)
            SEL_PC4: sel_npc_c = pc_plus4_c;
            SEL_J: begin
                sel_npc_c  = j_target_c;
                sel_xfer_c = 1'b1;
            end
            SEL_JR: begin
                sel_npc_c  = bus.RD1;
                sel_xfer_c = 1'b1;
            end
            SEL_BEQ, SEL_BNE, SEL_BLEZ, SEL_BGTZ: begin
                if (br_cond_c) begin
                    sel_npc_c  = br_target_c;
                    sel_xfer_c = 1'b1;
                end
            end
            SEL_ERET: begin
                sel_npc_c  = bus.EPC;
                sel_xfer_c = 1'b1;
                sel_eret_c = 1'b1;
            end
            default: sel_npc_c = pc_plus4_c;
        endcase
    end

    // Priority: Req > Stall > pending eret > D-stage selection
    always_comb begin
        pc_d    = sel_npc_c;
        state_d = state_q;
        flush_c = 1'b0;
        taken_c = 1'b0;

        if (!bus.Stall) begin
            taken_c = (state_q == ERET_WAIT) ? 1'b1 : sel_xfer_c;
        end

        if (bus.Req) begin
            pc_d    = HANDLER_PC;
            state_d = RUN;
        end else if (bus.Stall) begin
            pc_d = pc_q;
            if (state_q == RUN && sel_eret_c) begin
                state_d = ERET_WAIT;
            end
        end else if (state_q == ERET_WAIT) begin
            pc_d    = bus.EPC;
            flush_c = 1'b1;
            state_d = RUN;
        end else begin
            flush_c = sel_eret_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign bus.PC_F      = pc_q;
    assign bus.NPC       = pc_d;
    assign bus.flush     = flush_c;
    assign bus.taken     = taken_c;
    assign bus.ExcAdEL_F = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table, hand-written corner sequences,
// then random stimulus against a rule-level reference model.
module tb_pc_ctrl;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_ctrl_if #(.SEL_W(3)) bus ();

    pc_ctrl #(
        .RESET_PC  (RESET_PC),
        .HANDLER_PC(HANDLER_PC),
        .TEXT_LO   (32'h0000_3000),
        .TEXT_HI   (32'h0000_6ffc),
        .SEL_W     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]  sel;
        logic        brz;
        logic        stall;
        logic        req;
        logic [31:0] pcd;
        logic [31:0] ext;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [25:0] imm;
        logic [31:0] epc;
        logic [31:0] npc;
        logic        taken;
        logic        flush;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] sel, input logic brz, input logic stall,
                                input logic req, input logic [31:0] pcd, input logic [31:0] ext,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [25:0] imm, input logic [31:0] epc,
                                input logic [31:0] npc, input logic taken, input logic flush);
        vec_t v;
        v.sel = sel; v.brz = brz; v.stall = stall; v.req = req;
        v.pcd = pcd; v.ext = ext; v.rd1 = rd1; v.rd2 = rd2;
        v.imm = imm; v.epc = epc; v.npc = npc; v.taken = taken; v.flush = flush;
        return v;
    endfunction

    function automatic logic bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6ffc);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs, clock, check the new PC
    task automatic apply(input vec_t v, input string nm);
        bus.nPC_sel = v.sel;  bus.brz_sel = v.brz; bus.Stall = v.stall; bus.Req = v.req;
        bus.PC_D    = v.pcd;  bus.EXT     = v.ext; bus.RD1   = v.rd1;   bus.RD2 = v.rd2;
        bus.imm26   = v.imm;  bus.EPC     = v.epc;
        #1;
        chk({nm, ".npc"},   bus.NPC,   v.npc);
        chk({nm, ".taken"}, 32'(bus.taken), 32'(v.taken));
        chk({nm, ".flush"}, 32'(bus.flush), 32'(v.flush));
        @(posedge clk);
        #1;
        chk({nm, ".pc_f"},  bus.PC_F,  v.npc);
        chk({nm, ".adel"},  32'(bus.ExcAdEL_F), 32'(bad_addr(v.npc)));
    endtask

    vec_t tbl[$];

    // Random phase reference state
    logic [31:0] m_pc;
    bit          m_wait;

    initial begin
        reset = 1'b1;
        bus.nPC_sel = '0; bus.brz_sel = 1'b0; bus.Stall = 1'b0; bus.Req = 1'b0;
        bus.PC_D = '0; bus.EXT = '0; bus.RD1 = '0; bus.RD2 = '0; bus.imm26 = '0; bus.EPC = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.pc_f", bus.PC_F, RESET_PC);
        chk("reset.adel", 32'(bus.ExcAdEL_F), 32'd0);
        chk("reset.flush", 32'(bus.flush), 32'd0);
        reset = 1'b0;

        // sel, brz, stall, req, PC_D, EXT, RD1, RD2, imm26, EPC, NPC, taken, flush
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300c, 0, 0));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3010, 0, 0));
        tbl.push_back(mk(3'd3, 0, 0, 0, 32'h3010, 32'hffff_fffc, 5, 5, 0, 0, 32'h3004, 1, 0));
        tbl.push_back(mk(3'd3, 0, 0, 0, 32'h3010, 32'hffff_fffc, 5, 6, 0, 0, 32'h3008, 0, 0));
        tbl.push_back(mk(3'd5, 1, 0, 0, 32'h3010, 32'd4, 32'h8000_0000, 0, 0, 0, 32'h3024, 1, 0));
        tbl.push_back(mk(3'd6, 1, 0, 0, 32'h3024, 32'd1, 0, 0, 0, 0, 32'h302c, 1, 0));
        tbl.push_back(mk(3'd6, 0, 0, 0, 32'h3024, 32'd1, 0, 0, 0, 0, 32'h3030, 0, 0));
        tbl.push_back(mk(3'd5, 0, 0, 0, 32'h3030, 32'd2, 0, 0, 0, 0, 32'h303c, 1, 0));
        tbl.push_back(mk(3'd4, 0, 0, 0, 32'h303c, 32'd0, 1, 2, 0, 0, 32'h3040, 1, 0));
        tbl.push_back(mk(3'd1, 0, 0, 0, 32'h3040, 0, 0, 0, 26'h000_0c00, 0, 32'h3000, 1, 0));
        tbl.push_back(mk(3'd1, 0, 1, 0, 32'h3040, 0, 0, 0, 26'h000_0c00, 0, 32'h3000, 0, 0));
        tbl.push_back(mk(3'd2, 0, 0, 0, 0, 0, 32'h5000, 0, 0, 0, 32'h5000, 1, 0));
        tbl.push_back(mk(3'd4, 0, 0, 0, 32'h3000, 0, 7, 7, 0, 0, 32'h5004, 0, 0));
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // eret blocked by stall for three cycles, then retried with nPC_sel back at PC4
        for (int i = 0; i < 3; i++)
            apply(mk(3'd7, 0, 1, 0, 0, 0, 0, 0, 0, 32'h3040, 32'h5004, 0, 0), "eret_stall");
        apply(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3040, 32'h3040, 1, 1), "eret_retry");
        apply(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3040, 32'h3044, 0, 0), "eret_done");

        // Req beats stall and jump; Req with eret neither flushes nor arms the retry
        apply(mk(3'd1, 0, 1, 1, 32'h3000, 0, 0, 0, 26'h155, 0, HANDLER_PC, 0, 0), "req_stall_j");
        apply(mk(3'd7, 0, 1, 1, 0, 0, 0, 0, 0, 32'h3040, HANDLER_PC, 0, 0), "req_eret_st");
        apply(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3040, 32'h4184, 0, 0), "req_no_wait");
        apply(mk(3'd7, 0, 0, 1, 0, 0, 0, 0, 0, 32'h3040, HANDLER_PC, 1, 0), "req_eret");

        // Address legality boundaries and wrap-around
        apply(mk(3'd2, 0, 0, 0, 0, 0, 32'h3002, 0, 0, 0, 32'h3002, 1, 0), "jr_misalign");
        apply(mk(3'd2, 0, 0, 0, 0, 0, 32'h7000, 0, 0, 0, 32'h7000, 1, 0), "jr_above");
        apply(mk(3'd2, 0, 0, 0, 0, 0, 32'h6ffc, 0, 0, 0, 32'h6ffc, 1, 0), "jr_top");
        apply(mk(3'd2, 0, 0, 0, 0, 0, 32'h2ffc, 0, 0, 0, 32'h2ffc, 1, 0), "jr_below");
        apply(mk(3'd2, 0, 0, 0, 0, 0, 32'hffff_fffc, 0, 0, 0, 32'hffff_fffc, 1, 0), "jr_max");
        apply(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0), "wrap");

        // Arm eret retry, then reset asynchronously mid-cycle
        apply(mk(3'd7, 0, 1, 0, 0, 0, 0, 0, 0, 32'h3040, 32'h0, 0, 0), "arm_wait");
        bus.nPC_sel = 3'd0; bus.Stall = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst.pc_f", bus.PC_F, RESET_PC);
        chk("async_rst.adel", 32'(bus.ExcAdEL_F), 32'd0);
        chk("async_rst.flush", 32'(bus.flush), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3040, 32'h3004, 0, 0), "post_rst");

        // Random stimulus against the rule-level model
        m_pc   = 32'h3004;
        m_wait = 1'b0;
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            int signed a, b;
            bit cond, xfer;
            logic [31:0] tgt;
            v.sel   = 3'($urandom_range(0, 7));
            v.brz   = 1'($urandom_range(0, 1));
            v.stall = ($urandom_range(0, 3) == 0);
            v.req   = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 4))
                0:       v.rd1 = 32'h0;
                1:       v.rd1 = 32'h8000_0000;
                2:       v.rd1 = 32'h7fff_ffff;
                3:       v.rd1 = 32'hffff_ffff;
                default: v.rd1 = $urandom;
            endcase
            v.rd2 = ($urandom_range(0, 1) == 1) ? v.rd1 : $urandom;
            v.pcd = $urandom & 32'hffff_fffc;
            v.ext = 32'($urandom_range(0, 255)) - 32'd128;
            v.imm = 26'($urandom);
            v.epc = $urandom;

            a = v.rd1;
            b = v.rd2;
            case (v.sel)
                3'd3:    cond = (a == b);
                3'd4:    cond = (a != b);
                3'd5:    cond = v.brz ? (a < 0) : (a <= 0);
                3'd6:    cond = v.brz ? (a >= 0) : (a > 0);
                default: cond = 1'b0;
            endcase
            xfer = (v.sel == 3'd1) || (v.sel == 3'd2) || (v.sel == 3'd7) || cond;

            case (v.sel)
                3'd1:    tgt = {v.pcd[31:28], v.imm, 2'b00};
                3'd2:    tgt = v.rd1;
                3'd7:    tgt = v.epc;
                default: tgt = cond ? v.pcd + 32'd4 + v.ext * 32'd4 : m_pc + 32'd4;
            endcase

            if (v.req)        v.npc = HANDLER_PC;
            else if (v.stall) v.npc = m_pc;
            else if (m_wait)  v.npc = v.epc;
            else              v.npc = tgt;
            v.taken = !v.stall && (m_wait || xfer);
            v.flush = !v.req && !v.stall && (m_wait || v.sel == 3'd7);

            apply(v, $sformatf("rand%0d", n));
            m_pc   = v.npc;
            m_wait = !v.req && v.stall && (m_wait || v.sel == 3'd7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised successor to the fetch-stage next-PC unit. It owns the F-stage PC register and selects the next PC from several sources:
- sequential fetch;
- D-stage branches, with a generalised six-condition compare;
- j/jal and jr/jalr;
- eret;
- the CP0 exception/interrupt request.

It also raises the fetch address exception (AdEL) and a one-cycle delay-slot flush for eret. It sits between IM and the F/D register and takes its control from the D-stage decoder and CP0.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into the PC on reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry vector.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address.
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address (inclusive).
- SEL_W, 3, width of nPC_sel.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Stall  in  1  D-stage stall from the hazard unit; holds the PC.
- Req  in  1  CP0 exception/interrupt request; highest non-reset priority.
- EPC  in  32  return address from CP0.
- PC_D  in  32  PC of the instruction currently in D.
- imm26  in  26  jump index of the D instruction.
- EXT  in  32  sign-extended branch offset of the D instruction.
- RD1  in  32  forwarded rs value.
- RD2  in  32  forwarded rt value.
- nPC_sel  in  SEL_W  encoding: 0 PC4, 1 j/jal, 2 jr/jalr, 3 beq, 4 bne, 5 blez, 6 bgtz, 7 eret.
- brz_sel  in  1  when nPC_sel=5/6, 0 selects blez/bgtz. When brz_sel=1, code 5 becomes bltz and code 6 becomes bgez.
- PC_F  out  32  current fetch address (registered).
- NPC  out  32  next PC (combinational, for visibility).
- flush  out  1  clear the F/D register this cycle.
- ExcAdEL_F  out  1  the current PC_F is illegal for fetch.
- taken  out  1  the D-stage control transfer is taken this cycle.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - PC_F=RESET_PC and the internal state returns to RUN.
  - Combinational outputs then follow from the reset state: flush=0; taken=0 unless the D inputs demand it; ExcAdEL_F evaluated on RESET_PC.
- Next-PC priority, evaluated every cycle and loaded on the rising edge:
  1. Req → NPC=HANDLER_PC, flush=0. The Stall value is ignored.
  2. Stall → NPC=PC_F. flush=0 and taken=0, even if nPC_sel names a jump or eret; the D instruction re-issues next cycle.
  3. Otherwise NPC is chosen by nPC_sel, per the rules below.
- nPC_sel rules (priority step 3):
  - PC4 → PC_F+4.
  - j → {PC_D[31:28], imm26, 2'b00}.
  - jr → RD1.
  - Branch → PC_D+4+(EXT<<2) if the condition holds, else PC_F+4.
  - eret → EPC, flush=1.
  - Undefined codes (only when SEL_W>3) behave as PC4.
- Branch conditions, all compares signed 32-bit:
  - beq: RD1==RD2.
  - bne: RD1!=RD2.
  - blez: RD1<=0.
  - bgtz: RD1>0.
  - bltz: RD1<0.
  - bgez: RD1>=0.
- taken=1 when:
  - j or jr is selected and not stalled; or
  - a branch condition holds and not stalled; or
  - eret is selected and not stalled.
- Arithmetic: all additions are modulo 2^32. 32'hffff_fffc+4 wraps to 0, and 0 is then flagged by ExcAdEL_F.
- ExcAdEL_F=1 when PC_F[1:0]!=0, PC_F<TEXT_LO or PC_F>TEXT_HI. It is combinational from the register. The PC still advances normally; CP0 raises Req later.
- State machine, used to retry an eret that is blocked by stall:
  - RUN → ERET_WAIT when nPC_sel=eret and Stall=1 and Req=0.
  - ERET_WAIT holds while Stall=1.
  - On the first cycle in ERET_WAIT with Stall=0: NPC=EPC, flush=1, taken=1, then return to RUN. This happens whatever the value of nPC_sel.
  - Req in any state → NPC=HANDLER_PC, next state RUN.
- Simultaneous Req and eret: Req wins. flush=0, and no ERET_WAIT entry is made.
- Latency:
  - Redirect targets appear on PC_F one cycle after the decision edge.
  - flush is asserted in the same cycle as the decision, so the F/D register clears on that edge.

Test Plan:
1. Reset held, then released → PC_F=0x3000. Next four edges → 0x3004, 0x3008, 0x300c, 0x3010.
2. beq with PC_D=0x3010, EXT=0xffff_fffc, RD1=RD2=5 → NPC=0x3004, taken=1. Repeat with RD2=6 → NPC=PC_F+4, taken=0.
3. brz_sel=1 with nPC_sel=5 (bltz), RD1=0x8000_0000 → taken. Then nPC_sel=6 (bgez), RD1=0 → taken. Then nPC_sel=6 with brz_sel=0 (bgtz), RD1=0 → not taken.
4. eret with EPC=0x3040 and Stall=1 for 3 cycles → PC_F held, flush=0, taken=0. Stall drops → flush=1, taken=1, next PC_F=0x3040.
5. Req together with nPC_sel=j and Stall=1 → PC_F=0x4180 next edge, flush=0.
6. jr with RD1=0x3002 → PC_F=0x3002 and ExcAdEL_F=1. Then jr with RD1=0x7000 → ExcAdEL_F=1. Assert reset asynchronously mid-cycle → PC_F=0x3000 immediately, ExcAdEL_F=0.
